// File: rtl/calc_pkg.sv
// ============================================================================
// calc_pkg : shared state, command and status encodings for the calculator
// Revision : 1.0
// ============================================================================
`default_nettype none

package calc_pkg;

    typedef enum logic [2:0] {
        S_WAIT_A = 3'd0,
        S_WAIT_B = 3'd1,
        S_CALC   = 3'd2,
        S_PRINT  = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    localparam logic [3:0] CMD_ADD  = 4'd10;
    localparam logic [3:0] CMD_SUB  = 4'd11;
    localparam logic [3:0] CMD_MUL  = 4'd12;
    localparam logic [3:0] CMD_DIV  = 4'd13;
    localparam logic [3:0] CMD_EQ   = 4'd14;
    localparam logic [3:0] CMD_BKSP = 4'd15;

    localparam logic [1:0] STAT_ERROR = 2'b00;
    localparam logic [1:0] STAT_BUSY  = 2'b01;
    localparam logic [1:0] STAT_READY = 2'b10;
    localparam logic [1:0] STAT_PRINT = 2'b11;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/calc_bcd_print.sv
// ============================================================================
// calc_bcd_print : emits NDIG decimal digits of a binary value, LSD first
// Revision       : 1.0
// ============================================================================
`default_nettype none

module calc_bcd_print #(
    parameter int NDIG = 8,
    parameter int VW   = 27
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [VW-1:0]           value,
    output logic [3:0]              data,
    output logic [$clog2(NDIG)-1:0] pos,
    output logic                    data_valid,
    output logic                    done
);

    localparam int             PW       = $clog2(NDIG);
    localparam logic [PW-1:0]  LAST_POS = PW'(NDIG - 1);
    localparam logic [VW-1:0]  TEN      = VW'(10);

    logic [VW-1:0] val;
    logic [PW-1:0] cnt;
    logic          active;

    // The remaining value is divided by ten each cycle; its remainder is the digit on show.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            val    <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            val    <= value;
            cnt    <= '0;
            active <= 1'b1;
        end else if (active) begin
            val <= val / TEN;
            if (cnt == LAST_POS) begin
                active <= 1'b0;
                cnt    <= '0;
            end else begin
                cnt <= cnt + PW'(1);
            end
        end
    end

    assign data       = active ? 4'(val % TEN) : 4'd0;
    assign pos        = cnt;
    assign data_valid = active;
    assign done       = active && (cnt == LAST_POS);

endmodule

`default_nettype wire

// File: rtl/calc_ndigit.sv
// ============================================================================
// calc_ndigit : NDIG-digit decimal calculator with keypad commands and a
//               digit-serial result print
// Revision    : 1.0
// ============================================================================
`default_nettype none

module calc_ndigit
    import calc_pkg::*;
#(
    parameter int NDIG = 8,
    parameter int VW   = 27
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [3:0]              cmd,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    output logic [1:0]              status,
    output logic [3:0]              data,
    output logic [$clog2(NDIG)-1:0] pos,
    output logic                    data_valid,
    output logic [2:0]              state
);

    localparam int               CW        = $clog2(VW);
    localparam logic [VW-1:0]    FULL_DIG  = VW'(pow10(NDIG - 1));
    localparam logic [2*VW-1:0]  LIMIT     = (2*VW)'(pow10(NDIG));
    localparam logic [CW-1:0]    LAST_STEP = CW'(VW - 1);
    localparam logic [VW-1:0]    TEN       = VW'(10);

    state_t          cur_state, next_state, ret_state, ret_next;
    logic [VW-1:0]   acc, acc_next, reg_a, reg_a_next, reg_b, reg_b_next;
    logic [3:0]      op, op_next;
    logic            alive, accept, calc_init, prt_start, prt_done;
    logic            calc_done, calc_err;
    logic [CW-1:0]   step;
    logic [2*VW-1:0] prod, prod_step, mcand, result;
    logic [VW-1:0]   mplier, quo, quo_step, rem, rem_step;
    logic [VW:0]     rem_shift;

    // alive holds cmd_ready low until the first edge after reset release.
    assign cmd_ready = alive && ((cur_state == S_WAIT_A) || (cur_state == S_WAIT_B));
    assign accept    = cmd_valid && cmd_ready;
    assign state     = cur_state;

    always_comb begin
        status = STAT_READY;
        case (cur_state)
            S_CALC:  status = STAT_BUSY;
            S_PRINT: status = STAT_PRINT;
            S_ERROR: status = STAT_ERROR;
            default: status = STAT_READY;
        endcase
    end

    // One shift-add step and one restoring-division step per CALC cycle.
    always_comb begin
        prod_step = prod + (mplier[0] ? mcand : '0);
        rem_shift = {rem, quo[VW-1]};
        if (rem_shift >= {1'b0, reg_b}) begin
            rem_step = VW'(rem_shift - {1'b0, reg_b});
            quo_step = {quo[VW-2:0], 1'b1};
        end else begin
            rem_step = rem_shift[VW-1:0];
            quo_step = {quo[VW-2:0], 1'b0};
        end

        result    = '0;
        calc_done = 1'b0;
        calc_err  = 1'b0;
        case (op)
            CMD_ADD: begin
                result    = {{VW{1'b0}}, reg_a} + {{VW{1'b0}}, reg_b};
                calc_done = 1'b1;
            end
            CMD_SUB: begin
                result    = {{VW{1'b0}}, reg_a - reg_b};
                calc_err  = (reg_b > reg_a);
                calc_done = 1'b1;
            end
            CMD_MUL: begin
                result    = prod_step;
                calc_done = (step == LAST_STEP);
            end
            default: begin
                result    = {{VW{1'b0}}, quo_step};
                calc_err  = (reg_b == '0);
                calc_done = calc_err || (step == LAST_STEP);
            end
        endcase
        if (result >= LIMIT) calc_err = 1'b1;
    end

    always_comb begin
        next_state = cur_state;
        ret_next   = ret_state;
        acc_next   = acc;
        reg_a_next = reg_a;
        reg_b_next = reg_b;
        op_next    = op;
        calc_init  = 1'b0;
        prt_start  = 1'b0;
        case (cur_state)
            S_WAIT_A, S_WAIT_B: begin
                if (accept) begin
                    if (cmd <= 4'd9) begin
                        if (acc < FULL_DIG) acc_next = acc * TEN + {{(VW-4){1'b0}}, cmd};
                        prt_start = 1'b1;
                        ret_next  = cur_state;
                    end else if (cmd == CMD_BKSP) begin
                        acc_next  = acc / TEN;
                        prt_start = 1'b1;
                        ret_next  = cur_state;
                    end else if (cmd == CMD_EQ) begin
                        if (cur_state == S_WAIT_B) begin
                            reg_b_next = acc;
                            calc_init  = 1'b1;
                            next_state = S_CALC;
                        end
                    end else begin
                        op_next   = cmd;
                        prt_start = 1'b1;
                        ret_next  = S_WAIT_B;
                        if (cur_state == S_WAIT_A) begin
                            reg_a_next = acc;
                            acc_next   = '0;
                        end
                    end
                    if (prt_start) next_state = S_PRINT;
                end
            end
            S_CALC: begin
                if (calc_done) begin
                    if (calc_err) begin
                        next_state = S_ERROR;
                    end else begin
                        acc_next   = result[VW-1:0];
                        reg_a_next = result[VW-1:0];
                        ret_next   = S_WAIT_A;
                        prt_start  = 1'b1;
                        next_state = S_PRINT;
                    end
                end
            end
            S_PRINT: begin
                if (prt_done) next_state = ret_state;
            end
            S_ERROR: next_state = S_ERROR;
            default: next_state = S_WAIT_A;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur_state <= S_WAIT_A;
            ret_state <= S_WAIT_A;
            acc       <= '0;
            reg_a     <= '0;
            reg_b     <= '0;
            op        <= '0;
            alive     <= 1'b0;
        end else begin
            cur_state <= next_state;
            ret_state <= ret_next;
            acc       <= acc_next;
            reg_a     <= reg_a_next;
            reg_b     <= reg_b_next;
            op        <= op_next;
            alive     <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            step   <= '0;
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
            quo    <= '0;
            rem    <= '0;
        end else if (calc_init) begin
            step   <= '0;
            prod   <= '0;
            mcand  <= {{VW{1'b0}}, reg_a};
            mplier <= acc;
            quo    <= reg_a;
            rem    <= '0;
        end else if (cur_state == S_CALC) begin
            step   <= step + CW'(1);
            prod   <= prod_step;
            mcand  <= {mcand[2*VW-2:0], 1'b0};
            mplier <= {1'b0, mplier[VW-1:1]};
            quo    <= quo_step;
            rem    <= rem_step;
        end
    end

    calc_bcd_print #(
        .NDIG (NDIG),
        .VW   (VW)
    ) u_print (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (prt_start),
        .value      (acc_next),
        .data       (data),
        .pos        (pos),
        .data_valid (data_valid),
        .done       (prt_done)
    );

endmodule

`default_nettype wire
